// File: rtl/vec_pkg.sv
// ---------------------------------------------------------------------------
// vec_pkg
// Shared definitions for the lane-parallel vector datapath: lane geometry,
// the lane-index width and the store-unit state encoding.
// Used by vector_store_unit and vec_lane_select (and a future load unit).
// ---------------------------------------------------------------------------
package vec_pkg;

   localparam int LANE_W     = 8;
   localparam int LANES      = 6;
   localparam int VEC_W      = LANE_W * LANES;
   localparam int LANE_IDX_W = $clog2(LANES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_DONE
   } vst_state_t;

endpackage : vec_pkg

// File: rtl/vec_lane_select.sv
// ---------------------------------------------------------------------------
// vec_lane_select
// Purely combinational lane multiplexer: returns lane idx of a packed vector,
// where lane i occupies vec[LANE_W*i +: LANE_W]. An index beyond the last
// lane returns zero.
// Ports:
//   vec   in  N         packed vector
//   idx   in  IDX_W     lane index
//   lane  out LANE_W    selected lane
// ---------------------------------------------------------------------------
module vec_lane_select
   import vec_pkg::*;
#(
   parameter int N      = VEC_W,
   parameter int LW     = LANE_W,
   parameter int IDX_W  = LANE_IDX_W
) (
   input  logic [N-1:0]     vec,
   input  logic [IDX_W-1:0] idx,
   output logic [LW-1:0]    lane
);

   // Compare-and-select over all lanes keeps the index arithmetic out of the
   // part-select and gives a clean AND-OR mux.
   always_comb begin
      lane = '0;
      for (int i = 0; i < N / LW; i++) begin
         if (idx == IDX_W'(i)) begin
            lane = vec[LW*i +: LW];
         end
      end
   end

endmodule : vec_lane_select

// File: rtl/vector_store_unit.sv
// ---------------------------------------------------------------------------
// vector_store_unit
// Accepts one packed vector (six 8-bit lanes) through a valid/ready
// handshake and writes it to byte-addressed memory, one lane per cycle,
// lane 0 first, followed by a one-cycle done pulse. Masked-off lanes still
// take their cycle so the latency is always LANES + 1 cycles.
// Ports:
//   clk, rst           clock (rising edge), async active-high reset
//   st_valid/st_ready  request handshake
//   st_data            packed vector, lane i = st_data[LANE_W*i +: LANE_W]
//   st_addr            base byte address
//   st_mask            per-lane write enable
//   mem_we/addr/wdata  registered byte write port
//   busy               high while lanes are being written
//   done               one-cycle completion pulse
// ---------------------------------------------------------------------------
module vector_store_unit
   import vec_pkg::*;
#(
   parameter int N      = VEC_W,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [N-1:0]      st_data,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [LANES-1:0]  st_mask,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LANE_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done
);

   vst_state_t              state_q, state_d;
   logic [LANE_IDX_W-1:0]   lane_q, lane_d;
   logic [N-1:0]            data_q, data_d;
   logic [ADDR_W-1:0]       base_q, base_d;
   logic [LANES-1:0]        mask_q, mask_d;
   logic                    mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
   logic [LANE_W-1:0]       mem_wdata_q, mem_wdata_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    handshake;
   logic                    write_lane;
   logic [LANE_W-1:0]       lane_byte;

   // Ready is decoded from the state only; it is forced low while reset is
   // held so no request can be taken during reset.
   assign st_ready  = (state_q != S_WRITE) && !rst;
   assign handshake = st_valid && (state_q != S_WRITE);

   // The mux looks at the *next* vector and lane so the selected byte can be
   // registered in the same edge that advances the lane counter.
   vec_lane_select #(
      .N     (N),
      .LW    (LANE_W),
      .IDX_W (LANE_IDX_W)
   ) u_lane_select (
      .vec  (data_d),
      .idx  (lane_d),
      .lane (lane_byte)
   );

   // Next-state and next-output logic. Every output is a register loaded
   // with the value for the upcoming cycle, so nothing reaches the memory
   // port combinationally from the inputs. Address and data hold outside
   // the write phase.
   always_comb begin
      state_d     = state_q;
      lane_d      = lane_q;
      data_d      = data_q;
      base_d      = base_q;
      mask_d      = mask_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      write_lane  = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (handshake) begin
               data_d     = st_data;
               base_d     = st_addr;
               mask_d     = st_mask;
               lane_d     = '0;
               state_d    = S_WRITE;
               write_lane = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            if (lane_q == LANE_IDX_W'(LANES - 1)) begin
               state_d = S_DONE;
            end else begin
               lane_d     = lane_q + LANE_IDX_W'(1);
               write_lane = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Address wraps naturally at ADDR_W bits.
      if (write_lane) begin
         mem_we_d    = mask_d[lane_d];
         mem_addr_d  = base_d + ADDR_W'(lane_d);
         mem_wdata_d = lane_byte;
      end

      busy_d = (state_d == S_WRITE);
      done_d = (state_d == S_DONE);
   end

   // State, capture and output registers; reset clears everything so an
   // aborted store stops writing at once and never signals done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         lane_q      <= '0;
         data_q      <= '0;
         base_q      <= '0;
         mask_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lane_q      <= lane_d;
         data_q      <= data_d;
         base_q      <= base_d;
         mask_q      <= mask_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule : vector_store_unit
